jump_unit: RTL and testbench

//  - Next-PC selection for the single-cycle KGP-RISC-style datapath; sits between the ALU/flag

---
 rtl/jump_pkg.sv | 24 ++
 rtl/branch_cond.sv | 38 +++
 rtl/jump_unit.sv | 81 ++++++++
 tb/tb_jump_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// jump_pkg: shared constants for the next-PC selection block.
//   - JUMP_AW       default address/data width
//   - PC_INCR       fall-through increment applied to the current PC
//   - COND_*        branch condition codes carried on the 'conditional' input
//   - FLAG_*        bit positions inside the {carry, sign, zero} flag vector
package jump_pkg;

  localparam int JUMP_AW = 32;
  localparam int PC_INCR = 4;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_Z    = 3'b001;
  localparam logic [2:0] COND_NZ   = 3'b010;
  localparam logic [2:0] COND_LTZ  = 3'b011;
  localparam logic [2:0] COND_GTZ  = 3'b100;
  localparam logic [2:0] COND_C    = 3'b101;
  localparam logic [2:0] COND_NC   = 3'b110;
  localparam logic [2:0] COND_RSV  = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch-condition evaluator.
//   conditional [2:0]  in   condition code (COND_*)
//   flags       [2:0]  in   {carry, sign, zero}
//   cond_ok            out  1 when the selected condition holds
module branch_cond
  import jump_pkg::*;
(
  input  logic [2:0] conditional,
  input  logic [2:0] flags,
  output logic       cond_ok
);

  logic w_z;
  logic w_s;
  logic w_c;

  assign w_z = flags[FLAG_Z];
  assign w_s = flags[FLAG_S];
  assign w_c = flags[FLAG_C];

  // Decode the condition code against the current flags.
  always_comb begin
    cond_ok = 1'b0;
    case (conditional)
      COND_NONE: cond_ok = 1'b0;
      COND_Z:    cond_ok = w_z;
      COND_NZ:   cond_ok = ~w_z;
      COND_LTZ:  cond_ok = w_s;
      // Strictly positive: neither negative nor zero.
      COND_GTZ:  cond_ok = ~w_s & ~w_z;
      COND_C:    cond_ok = w_c;
      COND_NC:   cond_ok = ~w_c;
      COND_RSV:  cond_ok = 1'b0;
      default:   cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_unit.sv
// jump_unit: next-PC selection, registered for the PC.
//   clk                 in   rising-edge clock
//   rst                 in   synchronous active-high reset
//   PCin         [AW]   in   current PC
//   address      [AW]   in   immediate/absolute jump target
//   res          [AW]   in   register/ALU-result jump target
//   AdSel               in   target select: 0 = address, 1 = res
//   unconditional       in   jump always taken
//   conditional  [2:0]  in   branch condition code
//   flags        [2:0]  in   {carry, sign, zero}
//   next_address [AW]   out  registered next PC
//   taken               out  registered: next_address is a target
module jump_unit
  import jump_pkg::*;
#(
  parameter int AW = JUMP_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] PCin,
  input  logic [AW-1:0] address,
  input  logic [AW-1:0] res,
  input  logic          AdSel,
  input  logic          unconditional,
  input  logic [2:0]    conditional,
  input  logic [2:0]    flags,
  output logic [AW-1:0] next_address,
  output logic          taken
);

  localparam logic [AW-1:0] PC_STEP = AW'(PC_INCR);

  logic [AW-1:0] w_target;
  logic [AW-1:0] w_fall;
  logic [AW-1:0] w_next;
  logic          w_cond_ok;
  logic          w_take;
  logic [AW-1:0] r_next_address;
  logic          r_taken;

  branch_cond u_branch_cond (
    .conditional (conditional),
    .flags       (flags),
    .cond_ok     (w_cond_ok)
  );

  // Fall-through wraps modulo 2^AW; the carry-out is intentionally dropped.
  assign w_fall = PCin + PC_STEP;
  assign w_take = unconditional | w_cond_ok;

  // Target mux and final next-PC selection.
  always_comb begin
    w_target = address;
    w_next   = w_fall;
    if (AdSel) begin
      w_target = res;
    end else begin
      w_target = address;
    end
    if (w_take) begin
      w_next = w_target;
    end else begin
      w_next = w_fall;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_address <= {AW{1'b0}};
      r_taken        <= 1'b0;
    end else begin
      r_next_address <= w_next;
      r_taken        <= w_take;
    end
  end

  assign next_address = r_next_address;
  assign taken        = r_taken;

endmodule

// File: tb/tb_jump_unit.sv
module tb_jump_unit;

  typedef struct {
    logic [31:0] pcin;
    logic [31:0] address;
    logic [31:0] res;
    logic        adsel;
    logic        unc;
    logic [2:0]  cond;
    logic [2:0]  flags;
    logic [31:0] exp_addr;
    logic        exp_taken;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        taken;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] PCin;
  logic [31:0] address;
  logic [31:0] res;
  logic        AdSel;
  logic        unconditional;
  logic [2:0]  conditional;
  logic [2:0]  flags;
  logic [31:0] next_address;
  logic        taken;

  int n_tests;
  int n_fail;
  exp_t sb[$];
  vec_t vecs[$];

  jump_unit #(.AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCin          (PCin),
    .address       (address),
    .res           (res),
    .AdSel         (AdSel),
    .unconditional (unconditional),
    .conditional   (conditional),
    .flags         (flags),
    .next_address  (next_address),
    .taken         (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Reference condition evaluation written as explicit flag tests.
  function automatic logic ref_take(input logic unc, input logic [2:0] cond, input logic [2:0] f);
    logic z, s, c;
    z = f[0]; s = f[1]; c = f[2];
    if (unc) return 1'b1;
    if (cond == 3'd1) return z;
    if (cond == 3'd2) return !z;
    if (cond == 3'd3) return s;
    if (cond == 3'd4) return (!s) && (!z);
    if (cond == 3'd5) return c;
    if (cond == 3'd6) return !c;
    return 1'b0;
  endfunction

  task automatic drive(input vec_t v);
    PCin = v.pcin; address = v.address; res = v.res; AdSel = v.adsel;
    unconditional = v.unc; conditional = v.cond; flags = v.flags;
  endtask

  // Drive at the falling edge, push expectation, compare just after the rising edge.
  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.addr = v.exp_addr; e.taken = v.exp_taken;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check32({name, ".addr"}, next_address, e.addr);
      check1({name, ".taken"}, taken, e.taken);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic adsel, input logic unc,
                              input logic [2:0] cond, input logic [2:0] f,
                              input logic [31:0] ea, input logic et);
    vec_t v;
    v.pcin = pc; v.address = 32'd35; v.res = 32'd45; v.adsel = adsel; v.unc = unc;
    v.cond = cond; v.flags = f; v.exp_addr = ea; v.exp_taken = et;
    return v;
  endfunction

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(mk(32'd2, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0, 1'b0));

    // Reset state
    @(posedge clk); #1;
    check32("reset.addr", next_address, 32'd0);
    check1("reset.taken", taken, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b000, 3'b000, 32'd6,  1'b0)); // fall-through
    vecs.push_back(mk(32'd2, 1'b0, 1'b1, 3'b000, 3'b000, 32'd35, 1'b1)); // unc imm
    vecs.push_back(mk(32'd2, 1'b1, 1'b1, 3'b000, 3'b000, 32'd45, 1'b1)); // unc reg
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b001, 3'b001, 32'd35, 1'b1)); // z taken
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b001, 3'b000, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b010, 3'b000, 32'd35, 1'b1)); // nz
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b010, 3'b001, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b011, 3'b010, 32'd35, 1'b1)); // ltz
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b011, 3'b000, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b100, 3'b000, 32'd35, 1'b1)); // gtz
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b100, 3'b010, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b100, 3'b001, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b101, 3'b100, 32'd35, 1'b1)); // c
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b101, 3'b000, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b110, 3'b000, 32'd35, 1'b1)); // nc
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b110, 3'b100, 32'd6,  1'b0));
    vecs.push_back(mk(32'd2, 1'b0, 1'b0, 3'b111, 3'b111, 32'd6,  1'b0)); // reserved
    vecs.push_back(mk(32'd2, 1'b0, 1'b1, 3'b111, 3'b111, 32'd35, 1'b1)); // unc overrides
    vecs.push_back(mk(32'd2, 1'b1, 1'b1, 3'b001, 3'b000, 32'd45, 1'b1));
    vecs.push_back(mk(32'd2, 1'b1, 1'b0, 3'b001, 3'b000, 32'd6,  1'b0)); // AdSel ignored
    vecs.push_back(mk(32'd2, 1'b1, 1'b0, 3'b101, 3'b100, 32'd45, 1'b1)); // cond via res
    vecs.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0, 1'b0)); // wrap

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomised vectors against the reference condition model
    for (int i = 0; i < 40; i++) begin
      logic tk;
      v.pcin = $urandom; v.address = $urandom; v.res = $urandom;
      v.adsel = 1'($urandom_range(1, 0)); v.unc = ($urandom_range(3, 0) == 0);
      v.cond = 3'($urandom_range(7, 0)); v.flags = 3'($urandom_range(7, 0));
      tk = ref_take(v.unc, v.cond, v.flags);
      v.exp_taken = tk;
      v.exp_addr  = tk ? (v.adsel ? v.res : v.address) : (v.pcin + 32'd4);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted during an unconditional jump
    @(negedge clk);
    drive(mk(32'd2, 1'b0, 1'b1, 3'b000, 3'b000, 32'd35, 1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    check32("rst_mid.addr", next_address, 32'd0);
    check1("rst_mid.taken", taken, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check32("rst_release.addr", next_address, 32'd35);
    check1("rst_release.taken", taken, 1'b1);

    // Latency: mid-cycle input changes show up only after the next rising edge
    @(negedge clk);
    drive(mk(32'd100, 1'b0, 1'b0, 3'b000, 3'b000, 32'd104, 1'b0));
    #2;
    check32("lat_hold1.addr", next_address, 32'd35);
    drive(mk(32'd200, 1'b1, 1'b1, 3'b000, 3'b000, 32'd45, 1'b1));
    #2;
    check32("lat_hold2.addr", next_address, 32'd35);
    check1("lat_hold2.taken", taken, 1'b1);
    @(posedge clk); #1;
    check32("lat_upd.addr", next_address, 32'd45);
    @(negedge clk);
    drive(mk(32'd200, 1'b0, 1'b0, 3'b000, 3'b000, 32'd204, 1'b0));
    #3;
    check32("lat_hold3.addr", next_address, 32'd45);
    @(posedge clk); #1;
    check32("lat_upd2.addr", next_address, 32'd204);
    check1("lat_upd2.taken", taken, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
